// File: rtl/mc_frontend_pkg.sv
// rtl/mc_frontend_pkg.sv - shared request types for the memory-controller front end
package mc_frontend_pkg;

  localparam int MC_DATA_WIDTH    = 16;
  localparam int MC_ADDRESS_WIDTH = 30;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  typedef struct packed {
    logic                        req_type;
    logic [MC_ADDRESS_WIDTH-1:0] address;
    logic [MC_DATA_WIDTH-1:0]    data;
  } mc_request_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock in-order request queue with wrap-bit pointers
module sync_fifo
  import mc_frontend_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  mc_request_t             push_data,
  input  logic                    pop,
  output mc_request_t             head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

  mc_request_t mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head reads as zero when empty so the downstream fields are clean after reset.
  assign head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/request_frontend.sv
// rtl/request_frontend.sv - client request queue, scheduler issue port and in-order read return
module request_frontend
  import mc_frontend_pkg::*;
#(
  parameter int DATA_WIDTH    = MC_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = MC_ADDRESS_WIDTH,
  parameter int FIFO_DEPTH    = 16,
  parameter int MAX_READS     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_request_type,
  input  logic [ADDRESS_WIDTH-1:0] in_request_address,
  input  logic [DATA_WIDTH-1:0]    in_request_data,
  output logic                     out_busy,
  output logic                     write_done,
  output logic                     read_done,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic                     req_type,
  output logic [ADDRESS_WIDTH-1:0] req_address,
  output logic [DATA_WIDTH-1:0]    req_data,
  input  logic                     rsp_valid,
  input  logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     unexpected_rsp
);

  localparam int               RIF_W    = $clog2(MAX_READS + 1);
  localparam int               CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [RIF_W-1:0] RIF_MAX  = RIF_W'(MAX_READS);
  localparam logic [RIF_W-1:0] RIF_ONE  = RIF_W'(1);
  localparam logic [CNT_W-1:0] FIFO_CAP = CNT_W'(FIFO_DEPTH);

  logic [RIF_W-1:0]      reads_in_flight_q, reads_in_flight_d;
  logic                  write_done_q, write_done_d;
  logic                  read_done_q, read_done_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  unexpected_rsp_q, unexpected_rsp_d;

  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  mc_request_t      push_req, head_req;
  logic             push, pop;
  logic             read_accept, rsp_expected;

  // Busy depends only on registered state, never on in_valid.
  assign out_busy = (fifo_count == FIFO_CAP) || (reads_in_flight_q == RIF_MAX);
  assign push     = in_valid && !out_busy && !fifo_full;
  assign pop      = req_valid && req_ready;
  assign push_req = {in_request_type, in_request_address, in_request_data};

  sync_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_req),
    .pop      (pop),
    .head     (head_req),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign req_valid   = !fifo_empty;
  assign req_type    = head_req.req_type;
  assign req_address = head_req.address;
  assign req_data    = head_req.data;

  always_comb begin
    reads_in_flight_d = reads_in_flight_q;
    unexpected_rsp_d  = unexpected_rsp_q;
    data_out_d        = data_out_q;
    read_done_d       = 1'b0;
    read_accept       = push && (in_request_type == REQ_READ);
    rsp_expected      = rsp_valid && (reads_in_flight_q != '0);
    write_done_d      = pop && (head_req.req_type == REQ_WRITE);

    if (read_accept && !rsp_expected) begin
      reads_in_flight_d = reads_in_flight_q + RIF_ONE;
    end else if (!read_accept && rsp_expected) begin
      reads_in_flight_d = reads_in_flight_q - RIF_ONE;
    end

    if (rsp_expected) begin
      read_done_d = 1'b1;
      data_out_d  = rsp_data;
    end

    // A response with nothing outstanding is flagged and otherwise dropped.
    if (rsp_valid && (reads_in_flight_q == '0)) unexpected_rsp_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reads_in_flight_q <= '0;
      write_done_q      <= 1'b0;
      read_done_q       <= 1'b0;
      data_out_q        <= '0;
      unexpected_rsp_q  <= 1'b0;
    end else begin
      reads_in_flight_q <= reads_in_flight_d;
      write_done_q      <= write_done_d;
      read_done_q       <= read_done_d;
      data_out_q        <= data_out_d;
      unexpected_rsp_q  <= unexpected_rsp_d;
    end
  end

  assign write_done     = write_done_q;
  assign read_done      = read_done_q;
  assign data_out       = data_out_q;
  assign unexpected_rsp = unexpected_rsp_q;

endmodule

// File: tb/tb_request_frontend.sv
// tb/tb_request_frontend.sv - randomized and directed bench with a queue-based reference model
module tb_request_frontend;

  localparam int FD = 16;
  localparam int MR = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_request_type;
  logic [29:0] in_request_address;
  logic [15:0] in_request_data;
  logic        out_busy;
  logic        write_done;
  logic        read_done;
  logic [15:0] data_out;
  logic        req_valid;
  logic        req_ready;
  logic        req_type;
  logic [29:0] req_address;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        unexpected_rsp;

  request_frontend dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_request_type   (in_request_type),
    .in_request_address(in_request_address),
    .in_request_data   (in_request_data),
    .out_busy          (out_busy),
    .write_done        (write_done),
    .read_done         (read_done),
    .data_out          (data_out),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_type          (req_type),
    .req_address       (req_address),
    .req_data          (req_data),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .unexpected_rsp    (unexpected_rsp)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a plain queue of requests plus a read counter.
  typedef struct {
    bit          t;
    logic [29:0] a;
    logic [15:0] d;
  } req_s;

  req_s        mq[$];
  logic [29:0] issued[$];
  int          m_rif;
  bit          m_wd, m_rd, m_unexp;
  logic [15:0] m_data;
  bit          check_en = 1'b0;

  function automatic void model_reset();
    mq.delete();
    m_rif   = 0;
    m_wd    = 0;
    m_rd    = 0;
    m_unexp = 0;
    m_data  = '0;
  endfunction

  function automatic void model_step();
    bit   busy, acc, pp;
    req_s h, n;
    busy = (mq.size() == FD) || (m_rif == MR);
    acc  = in_valid && !busy;
    pp   = (mq.size() > 0) && req_ready;
    m_wd = 0;
    m_rd = 0;
    if (pp) begin
      h    = mq.pop_front();
      m_wd = h.t;
      issued.push_back(h.a);
    end
    if (rsp_valid) begin
      if (m_rif > 0) begin
        m_rd   = 1;
        m_data = rsp_data;
        m_rif--;
      end else begin
        m_unexp = 1;
      end
    end
    if (acc) begin
      n.t = in_request_type;
      n.a = in_request_address;
      n.d = in_request_data;
      mq.push_back(n);
      if (!n.t) m_rif++;
    end
  endfunction

  function automatic void compare_all();
    bit          ht;
    logic [29:0] ha;
    logic [15:0] hd;
    ht = 0; ha = '0; hd = '0;
    if (mq.size() > 0) begin
      ht = mq[0].t; ha = mq[0].a; hd = mq[0].d;
    end
    chk("out_busy", 64'(out_busy), 64'((mq.size() == FD) || (m_rif == MR)));
    chk("req_valid", 64'(req_valid), 64'(mq.size() > 0));
    chk("req_type", 64'(req_type), 64'(ht));
    chk("req_address", 64'(req_address), 64'(ha));
    chk("req_data", 64'(req_data), 64'(hd));
    chk("write_done", 64'(write_done), 64'(m_wd));
    chk("read_done", 64'(read_done), 64'(m_rd));
    chk("data_out", 64'(data_out), 64'(m_data));
    chk("unexpected_rsp", 64'(unexpected_rsp), 64'(m_unexp));
  endfunction

  always @(posedge clk) begin
    if (check_en && rst_n) begin
      model_step();
      #1;
      compare_all();
    end
  end

  // Called at a negedge; returns at a negedge with in_valid dropped.
  task automatic send_req(input bit t, input logic [29:0] a, input logic [15:0] d,
                          input int budget, output bit acc);
    acc                = 0;
    in_valid           = 1'b1;
    in_request_type    = t;
    in_request_address = a;
    in_request_data    = d;
    for (int k = 0; k < budget && !acc; k++) begin
      if (!out_busy) acc = 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(out_busy), 0);
    chk({tag, "_req_valid"}, 64'(req_valid), 0);
    chk({tag, "_write_done"}, 64'(write_done), 0);
    chk({tag, "_read_done"}, 64'(read_done), 0);
    chk({tag, "_data_out"}, 64'(data_out), 0);
    chk({tag, "_req_type"}, 64'(req_type), 0);
    chk({tag, "_req_address"}, 64'(req_address), 0);
    chk({tag, "_req_data"}, 64'(req_data), 0);
    chk({tag, "_unexpected"}, 64'(unexpected_rsp), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bit          acc;
    logic [15:0] last_rsp;
    int          guard;

    rst_n = 1'b0; in_valid = 1'b0; in_request_type = 1'b0;
    in_request_address = '0; in_request_data = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    last_rsp = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n    = 1'b1;
    check_en = 1'b1;

    // Single write, ready high
    req_ready = 1'b1;
    send_req(1'b1, 30'h0000_0010, 16'hBEEF, 1, acc);
    chk("w1_acc", 64'(acc), 1);
    chk("w1_req_valid", 64'(req_valid), 1);
    chk("w1_req_type", 64'(req_type), 1);
    chk("w1_req_address", 64'(req_address), 64'h10);
    chk("w1_req_data", 64'(req_data), 64'hBEEF);
    @(negedge clk);
    chk("w1_write_done", 64'(write_done), 1);
    chk("w1_drained", 64'(req_valid), 0);
    issued.delete();

    // Fill the queue with ready low, then drain
    req_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send_req(1'b1, 30'h100 + 30'(i), 16'(i), 1, acc);
      chk("fill_acc", 64'(acc), 1);
    end
    send_req(1'b1, 30'h110, 16'h10, 1, acc);
    chk("full_reject", 64'(acc), 0);
    req_ready = 1'b1;
    send_req(1'b1, 30'h110, 16'h10, 5, acc);
    chk("full_retry_acc", 64'(acc), 1);
    guard = 0;
    while (req_valid && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_timeout", 64'(guard < 40), 1);
    chk("issue_count", 64'(issued.size()), 17);
    for (int k = 0; k < 17 && k < issued.size(); k++)
      chk("issue_order", 64'(issued[k]), 64'(30'h100 + 30'(k)));

    // Read limit
    for (int i = 0; i < 8; i++) begin
      send_req(1'b0, 30'h200 + 30'(i), 16'h0, 1, acc);
      chk("read_acc", 64'(acc), 1);
    end
    send_req(1'b0, 30'h208, 16'h0, 1, acc);
    chk("read_limit_reject", 64'(acc), 0);
    rsp_valid = 1'b1; rsp_data = 16'h1234;
    @(negedge clk);
    rsp_valid = 1'b0;
    last_rsp  = 16'h1234;
    chk("rsp_read_done", 64'(read_done), 1);
    chk("rsp_data_out", 64'(data_out), 64'h1234);
    chk("rsp_frees_busy", 64'(out_busy), 0);
    send_req(1'b0, 30'h208, 16'h0, 1, acc);
    chk("ninth_read_acc", 64'(acc), 1);

    // Accepted read and response in the same cycle keep the count level
    rsp_valid = 1'b1; rsp_data = 16'h0001;
    @(negedge clk);
    rsp_valid = 1'b0;
    last_rsp  = 16'h0001;
    rsp_valid = 1'b1; rsp_data = 16'h0002;
    send_req(1'b0, 30'h209, 16'h0, 1, acc);
    rsp_valid = 1'b0;
    last_rsp  = 16'h0002;
    chk("same_cycle_acc", 64'(acc), 1);
    chk("same_cycle_busy", 64'(out_busy), 0);
    send_req(1'b0, 30'h20A, 16'h0, 1, acc);
    chk("refill_acc", 64'(acc), 1);
    chk("refill_busy", 64'(out_busy), 1);

    guard = 0;
    while (m_rif > 0 && guard < 30) begin
      rsp_valid = 1'b1;
      rsp_data  = 16'($urandom);
      last_rsp  = rsp_data;
      @(negedge clk);
      guard++;
    end
    rsp_valid = 1'b0;
    chk("rsp_drain_timeout", 64'(guard < 30), 1);

    // Response with nothing in flight
    rsp_valid = 1'b1; rsp_data = 16'hDEAD;
    @(negedge clk);
    rsp_valid = 1'b0;
    chk("unexp_no_done", 64'(read_done), 0);
    chk("unexp_data_hold", 64'(data_out), 64'(last_rsp));
    chk("unexp_flag", 64'(unexpected_rsp), 1);
    @(negedge clk);
    chk("unexp_sticky", 64'(unexpected_rsp), 1);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      in_valid           = ($urandom_range(0, 3) != 0);
      in_request_type    = 1'($urandom_range(0, 1));
      in_request_address = 30'($urandom);
      in_request_data    = 16'($urandom);
      req_ready          = ($urandom_range(0, 2) != 0);
      rsp_valid          = ($urandom_range(0, 3) == 0);
      rsp_data           = 16'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;

    // Drain, then queue 5 requests with 3 reads outstanding and reset mid-flight
    req_ready = 1'b1;
    guard = 0;
    while ((req_valid || m_rif > 0) && guard < 100) begin
      rsp_valid = (m_rif > 0);
      rsp_data  = 16'($urandom);
      @(negedge clk);
      guard++;
    end
    rsp_valid = 1'b0;
    chk("final_drain_timeout", 64'(guard < 100), 1);
    req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_req((i >= 3), 30'h300 + 30'(i), 16'hA000 + 16'(i), 1, acc);
      chk("preload_acc", 64'(acc), 1);
    end
    #2;
    check_en = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    model_reset();
    rst_n    = 1'b1;
    check_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_req(1'b0, 30'h400 + 30'(i), 16'h0, 1, acc);
      chk("post_reset_read_acc", 64'(acc), 1);
    end
    send_req(1'b0, 30'h408, 16'h0, 1, acc);
    chk("post_reset_limit", 64'(acc), 0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
